// File: rtl/store_commit_queue_if.sv
// Store commit queue bus interface.
// Purpose : groups every handshake / data signal of store_commit_queue so the
//           design and its environment connect through one port.
// Signals : alloc  - allocValid_i, allocTag_i -> allocReady_o
//           fill   - fillValid_i, fillTag_i, fillAddr_i, fillData_i
//           commit - commitValid_i, commitTag_i
//           flush  - flush_i
//           drain  - memWrite_o, memAddr_o, memData_o <- memReady_i
//           load   - loadAddr_i -> loadHit_o, loadData_o
//           status - count_o, empty_o, commitErr_o
// Modports: slave  = the queue itself, master = the pipeline / memory side.
interface store_commit_queue_if #(
  parameter int ROBsize    = 32,
  parameter int ROBsizeLog = $clog2(ROBsize + 1),
  parameter int SQsize     = 8
);
  localparam int CW = $clog2(SQsize + 1);

  logic                  allocValid_i;
  logic [ROBsizeLog-1:0] allocTag_i;
  logic                  allocReady_o;
  logic                  fillValid_i;
  logic [ROBsizeLog-1:0] fillTag_i;
  logic [63:0]           fillAddr_i;
  logic [63:0]           fillData_i;
  logic                  commitValid_i;
  logic [ROBsizeLog-1:0] commitTag_i;
  logic                  flush_i;
  logic                  memWrite_o;
  logic [63:0]           memAddr_o;
  logic [63:0]           memData_o;
  logic                  memReady_i;
  logic [63:0]           loadAddr_i;
  logic                  loadHit_o;
  logic [63:0]           loadData_o;
  logic [CW-1:0]         count_o;
  logic                  empty_o;
  logic                  commitErr_o;

  modport slave (
    input  allocValid_i, allocTag_i, fillValid_i, fillTag_i, fillAddr_i,
           fillData_i, commitValid_i, commitTag_i, flush_i, memReady_i,
           loadAddr_i,
    output allocReady_o, memWrite_o, memAddr_o, memData_o, loadHit_o,
           loadData_o, count_o, empty_o, commitErr_o
  );

  modport master (
    output allocValid_i, allocTag_i, fillValid_i, fillTag_i, fillAddr_i,
           fillData_i, commitValid_i, commitTag_i, flush_i, memReady_i,
           loadAddr_i,
    input  allocReady_o, memWrite_o, memAddr_o, memData_o, loadHit_o,
           loadData_o, count_o, empty_o, commitErr_o
  );
endinterface

// File: rtl/store_commit_queue.sv
// Store commit queue.
// Purpose : circular store queue. Decode allocates entries in program order,
//           completion fills address/data by ROB tag (any order), commit
//           retires them in order, committed entries drain to data memory from
//           the head. Younger filled stores forward data to loads by address.
// Ports   : clk_i    - single clock, rising edge
//           reset_i  - synchronous active-high reset
//           sq       - store_commit_queue_if.slave (alloc / fill / commit /
//                      flush / drain / load lookup / status)
// SQsize must be a power of two >= 2 so pointer wrap is a natural overflow.
module store_commit_queue #(
  parameter int ROBsize    = 32,
  parameter int ROBsizeLog = $clog2(ROBsize + 1),
  parameter int SQsize     = 8
) (
  input logic                clk_i,
  input logic                reset_i,
  store_commit_queue_if.slave sq
);
  localparam int PW = $clog2(SQsize);
  localparam int CW = $clog2(SQsize + 1);

  typedef enum logic [1:0] {S_FREE, S_ALLOC, S_FILLED, S_COMMITTED} entry_state_e;

  entry_state_e          state_q [SQsize];
  entry_state_e          state_d [SQsize];
  logic [ROBsizeLog-1:0] tag_q   [SQsize];
  logic [ROBsizeLog-1:0] tag_d   [SQsize];
  logic [63:0]           addr_q  [SQsize];
  logic [63:0]           addr_d  [SQsize];
  logic [63:0]           data_q  [SQsize];
  logic [63:0]           data_d  [SQsize];

  logic [PW-1:0] head_q, head_d, cptr_q, cptr_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          err_q, err_d;

  logic              alloc_ready, alloc_fire, mem_write, drain_fire, commit_ok;
  logic [SQsize-1:0] fill_hit, fwd_match, is_committed;

  // Ready looks only at registered occupancy: a drain this cycle cannot open a slot.
  assign alloc_ready = (count_q < CW'(SQsize)) && !sq.flush_i;
  assign alloc_fire  = sq.allocValid_i && alloc_ready;
  assign mem_write   = (state_q[head_q] == S_COMMITTED);
  assign drain_fire  = mem_write && sq.memReady_i;
  assign commit_ok   = (state_q[cptr_q] == S_FILLED) && (tag_q[cptr_q] == sq.commitTag_i);

  for (genvar gi = 0; gi < SQsize; gi++) begin : g_entry
    assign fill_hit[gi] = sq.fillValid_i && tag_q[gi] == sq.fillTag_i &&
                          (state_q[gi] == S_ALLOC || state_q[gi] == S_FILLED);
    assign fwd_match[gi] = (state_q[gi] == S_FILLED || state_q[gi] == S_COMMITTED) &&
                           addr_q[gi] == sq.loadAddr_i;
    assign is_committed[gi] = (state_q[gi] == S_COMMITTED);
  end

  always_comb begin
    logic [CW-1:0] committed_cnt;
    state_d = state_q;
    tag_d   = tag_q;
    addr_d  = addr_q;
    data_d  = data_q;
    head_d  = head_q;
    cptr_d  = cptr_q;
    tail_d  = tail_q;
    count_d = count_q;
    err_d   = err_q;
    committed_cnt = '0;
    for (int i = 0; i < SQsize; i++) begin
      if (is_committed[i]) committed_cnt = committed_cnt + CW'(1);
    end

    if (!sq.flush_i) begin
      for (int i = 0; i < SQsize; i++) begin
        if (fill_hit[i]) begin
          addr_d[i]  = sq.fillAddr_i;
          data_d[i]  = sq.fillData_i;
          state_d[i] = S_FILLED;
        end
      end
      // Commit sees pre-edge state, so it overrides a same-cycle refill's FILLED.
      if (sq.commitValid_i) begin
        if (commit_ok) begin
          state_d[cptr_q] = S_COMMITTED;
          cptr_d          = cptr_q + PW'(1);
        end else begin
          err_d = 1'b1;
        end
      end
      if (alloc_fire) begin
        state_d[tail_q] = S_ALLOC;
        tag_d[tail_q]   = sq.allocTag_i;
        tail_d          = tail_q + PW'(1);
      end
      if (alloc_fire && !drain_fire)      count_d = count_q + CW'(1);
      else if (!alloc_fire && drain_fire) count_d = count_q - CW'(1);
    end else begin
      // Only committed entries survive; they all sit between head and commitPtr.
      for (int i = 0; i < SQsize; i++) begin
        if (state_q[i] == S_ALLOC || state_q[i] == S_FILLED) state_d[i] = S_FREE;
      end
      tail_d  = cptr_q;
      count_d = drain_fire ? committed_cnt - CW'(1) : committed_cnt;
    end

    if (drain_fire) begin
      state_d[head_q] = S_FREE;
      head_d          = head_q + PW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < SQsize; i++) state_q[i] <= S_FREE;
      head_q  <= '0;
      cptr_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      cptr_q  <= cptr_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
    // Payload needs no reset: it is only observed through a non-FREE state.
    tag_q  <= tag_d;
    addr_q <= addr_d;
    data_q <= data_d;
  end

  // Forwarding: walk oldest to youngest so the youngest match wins.
  always_comb begin
    logic [PW-1:0] idx;
    sq.loadHit_o  = 1'b0;
    sq.loadData_o = '0;
    idx = head_q;
    for (int k = 0; k < SQsize; k++) begin
      if (fwd_match[idx]) begin
        sq.loadHit_o  = 1'b1;
        sq.loadData_o = data_q[idx];
      end
      idx = idx + PW'(1);
    end
  end

  assign sq.allocReady_o = alloc_ready;
  assign sq.memWrite_o   = mem_write;
  assign sq.memAddr_o    = mem_write ? addr_q[head_q] : 64'd0;
  assign sq.memData_o    = mem_write ? data_q[head_q] : 64'd0;
  assign sq.count_o      = count_q;
  assign sq.empty_o      = (count_q == '0);
  assign sq.commitErr_o  = err_q;
endmodule

// File: tb/tb_store_commit_queue.sv
// Directed testbench for store_commit_queue; expected values are hand-computed.
module tb_store_commit_queue;
  logic clk_i = 1'b0;
  logic reset_i = 1'b0;
  int   checks = 0;
  int   errors = 0;

  store_commit_queue_if #(.ROBsize(32), .SQsize(8)) sq ();

  store_commit_queue #(.ROBsize(32), .SQsize(8)) dut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .sq      (sq)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    step();
    reset_i = 1'b0;
  endtask

  task automatic do_alloc(input logic [5:0] tag);
    sq.allocValid_i = 1'b1;
    sq.allocTag_i   = tag;
    step();
    sq.allocValid_i = 1'b0;
  endtask

  task automatic do_fill(input logic [5:0] tag, input logic [63:0] a, input logic [63:0] d);
    sq.fillValid_i = 1'b1;
    sq.fillTag_i   = tag;
    sq.fillAddr_i  = a;
    sq.fillData_i  = d;
    step();
    sq.fillValid_i = 1'b0;
  endtask

  task automatic do_commit(input logic [5:0] tag);
    sq.commitValid_i = 1'b1;
    sq.commitTag_i   = tag;
    step();
    sq.commitValid_i = 1'b0;
  endtask

  initial begin
    sq.allocValid_i = 0; sq.allocTag_i = 0;
    sq.fillValid_i = 0; sq.fillTag_i = 0; sq.fillAddr_i = 0; sq.fillData_i = 0;
    sq.commitValid_i = 0; sq.commitTag_i = 0; sq.flush_i = 0;
    sq.memReady_i = 0; sq.loadAddr_i = 0;
    #2;

    // Reset state
    do_reset();
    check("rst_count", sq.count_o, 0);
    check("rst_empty", sq.empty_o, 1);
    check("rst_ready", sq.allocReady_o, 1);
    check("rst_memwrite", sq.memWrite_o, 0);
    check("rst_memaddr", sq.memAddr_o, 0);
    check("rst_memdata", sq.memData_o, 0);
    check("rst_err", sq.commitErr_o, 0);
    check("rst_loadhit", sq.loadHit_o, 0);

    // Single store drains one cycle after commit
    sq.memReady_i = 1;
    do_alloc(5);
    check("single_count", sq.count_o, 1);
    check("single_nonempty", sq.empty_o, 0);
    do_fill(5, 64'h100, 64'hAB);
    check("single_prewrite", sq.memWrite_o, 0);
    do_commit(5);
    check("single_memwrite", sq.memWrite_o, 1);
    check("single_memaddr", sq.memAddr_o, 64'h100);
    check("single_memdata", sq.memData_o, 64'hAB);
    step();
    check("single_drained", sq.memWrite_o, 0);
    check("single_empty", sq.empty_o, 1);
    check("single_err", sq.commitErr_o, 0);

    // Drain outputs hold while memReady is low; same-cycle alloc+fill does not match
    sq.memReady_i = 0;
    sq.allocValid_i = 1; sq.allocTag_i = 9;
    sq.fillValid_i = 1; sq.fillTag_i = 9; sq.fillAddr_i = 64'h300; sq.fillData_i = 64'h55;
    step();
    sq.allocValid_i = 0; sq.fillValid_i = 0;
    sq.loadAddr_i = 64'h300;
    #1;
    check("samecyc_nohit", sq.loadHit_o, 0);
    do_fill(9, 64'h300, 64'h55);
    check("fill_hit", sq.loadHit_o, 1);
    check("fill_data", sq.loadData_o, 64'h55);
    do_commit(9);
    for (int i = 0; i < 3; i++) begin
      check("stall_memwrite", sq.memWrite_o, 1);
      check("stall_memaddr", sq.memAddr_o, 64'h300);
      step();
    end
    sq.memReady_i = 1;
    step();
    check("stall_drained_empty", sq.empty_o, 1);

    // Full queue: drain in same cycle does not make it accept
    do_reset();
    sq.memReady_i = 0;
    do_alloc(10);
    do_fill(10, 64'h400, 64'h4);
    do_commit(10);
    for (int i = 1; i < 8; i++) do_alloc(6'(10 + i));
    check("full_count", sq.count_o, 8);
    check("full_ready", sq.allocReady_o, 0);
    sq.memReady_i = 1;
    sq.allocValid_i = 1; sq.allocTag_i = 20;
    step();
    sq.allocValid_i = 0; sq.memReady_i = 0;
    check("full_reject_count", sq.count_o, 7);
    check("full_reopen_ready", sq.allocReady_o, 1);

    // Out-of-order fill, in-order commit and drain
    do_reset();
    do_alloc(1);
    do_alloc(2);
    do_fill(2, 64'h20, 64'h2);
    do_fill(1, 64'h10, 64'h1);
    do_commit(1);
    check("ooo_first_addr", sq.memAddr_o, 64'h10);
    do_commit(2);
    check("ooo_first_hold", sq.memAddr_o, 64'h10);
    sq.memReady_i = 1;
    step();
    check("ooo_second_write", sq.memWrite_o, 1);
    check("ooo_second_addr", sq.memAddr_o, 64'h20);
    check("ooo_second_data", sq.memData_o, 64'h2);
    step();
    check("ooo_empty", sq.empty_o, 1);
    check("ooo_err", sq.commitErr_o, 0);

    // Bad commit of an unfilled entry; flag is sticky
    do_reset();
    sq.memReady_i = 0;
    do_alloc(3);
    do_commit(3);
    check("bad_err", sq.commitErr_o, 1);
    check("bad_count", sq.count_o, 1);
    check("bad_memwrite", sq.memWrite_o, 0);
    do_fill(3, 64'h30, 64'h3);
    do_commit(3);
    check("bad_sticky", sq.commitErr_o, 1);
    check("bad_later_commit", sq.memWrite_o, 1);

    // Reset overrides a stalled drain
    do_reset();
    check("rst_mid_memwrite", sq.memWrite_o, 0);
    check("rst_mid_count", sq.count_o, 0);
    check("rst_mid_err", sq.commitErr_o, 0);

    // Flush keeps committed entries, drops the rest, ignores same-cycle alloc
    do_alloc(1);
    do_alloc(2);
    do_alloc(3);
    do_fill(1, 64'h110, 64'hA1);
    do_fill(2, 64'h120, 64'hA2);
    do_fill(3, 64'h130, 64'hA3);
    do_commit(1);
    sq.flush_i = 1; sq.allocValid_i = 1; sq.allocTag_i = 7;
    #1;
    check("flush_ready_low", sq.allocReady_o, 0);
    step();
    sq.flush_i = 0; sq.allocValid_i = 0;
    check("flush_count", sq.count_o, 1);
    check("flush_memaddr", sq.memAddr_o, 64'h110);
    sq.loadAddr_i = 64'h120;
    #1;
    check("flush_dropped_nohit", sq.loadHit_o, 0);
    sq.memReady_i = 1;
    step();
    check("flush_drain_empty", sq.empty_o, 1);
    sq.memReady_i = 0;
    do_alloc(4);
    do_fill(4, 64'h140, 64'hA4);
    do_commit(4);
    check("flush_tail_eq_cptr_err", sq.commitErr_o, 0);
    check("flush_new_memaddr", sq.memAddr_o, 64'h140);

    // Forwarding picks the youngest matching entry
    do_reset();
    do_alloc(1);
    do_alloc(2);
    do_fill(1, 64'h200, 64'h11);
    sq.loadAddr_i = 64'h200;
    #1;
    check("fwd_one_data", sq.loadData_o, 64'h11);
    do_fill(2, 64'h200, 64'h22);
    check("fwd_hit", sq.loadHit_o, 1);
    check("fwd_young_data", sq.loadData_o, 64'h22);
    do_commit(1);
    check("fwd_after_commit", sq.loadData_o, 64'h22);
    sq.loadAddr_i = 64'h208;
    #1;
    check("fwd_miss_hit", sq.loadHit_o, 0);
    check("fwd_miss_data", sq.loadData_o, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
